conv_layer_aer_encoder: RTL
===========================

Name: conv_layer_aer_encoder

Overview:
Transmit side of the inter-layer AER link. Collects spikes fired by a conv layer's neuron-update sweep as (M,N) coordinates and buffers them in a FIFO. Serialises them as 10-bit AER words {M[4:0],N[4:0]}, each with a single-cycle AER_output_flag, into the next layer's address generator. Paces emission so every event lands while the receiver is idle, and signals when a timestep's spikes have fully drained.

Parameters:
COORD_W, 5, width of each of M and N; AER word is 2*COORD_W
FIFO_DEPTH, 16, spike buffer entries (power of two)
GUARD_CYCLES, 3, cycles held after each pulse before re-sampling downstream_busy (covers receiver flag-to-operating_flag latency of 2)

Ports:
work_clk  in  1  clock
rst  in  1  asynchronous, active-high reset
spike_valid  in  1  one spike this cycle
spike_M  in  COORD_W  spike row
spike_N  in  COORD_W  spike column
timestep_end  in  1  pulse: sweep finished, no further spikes this timestep
downstream_busy  in  1  receiver operating_flag
AER_out  out  2*COORD_W  {M,N} of current event
AER_output_flag  out  1  one-cycle event strobe
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
overflow_flag  out  1  sticky: a spike was dropped
timestep_done  out  1  one-cycle pulse: timestep fully transmitted

Behaviour:
- Reset (async, rst=1): FIFO emptied (pointers 0). State S_IDLE. Done-pending cleared. All outputs 0.
- FIFO write: spike_valid && !fifo_full at the clock edge stores {spike_M,spike_N}.
- Spike while full: dropped, no write-through even if a pop occurs the same cycle. overflow_flag <= 1, held until reset.
- Pointers wrap modulo FIFO_DEPTH. Count width log2(FIFO_DEPTH)+1. fifo_full is registered, derived from count.
- FSM, one-hot 3-bit: S_IDLE=001, S_SEND=010, S_GUARD=100.
- S_IDLE: if FIFO non-empty && !downstream_busy, pop head, AER_out <= head, go to S_SEND. Otherwise stay.
- S_SEND: AER_output_flag = 1 for exactly this cycle. Guard counter loaded with GUARD_CYCLES. Go to S_GUARD.
- S_GUARD: decrement counter. At 0, go to S_IDLE. downstream_busy is ignored while in S_GUARD.
- AER_output_flag is registered, high only in S_SEND.
- AER_out holds its value from pop until the next pop; the receiver reads it throughout its operation.
- Minimum spacing between strobes: GUARD_CYCLES+2 cycles.
- Latency on an empty FIFO with busy=0: spike_valid at edge t gives flag high in cycle t+2.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Events leave in arrival order.
- timestep_end sets done-pending; repeated pulses while pending merge.
- timestep_done pulses when all of these hold in one cycle: pending, FIFO empty, S_IDLE, !downstream_busy, !spike_valid. Pending then clears.
- A spike coincident with timestep_end is accepted and transmitted before timestep_done.
- Reset mid-operation aborts any event in flight. No strobe is emitted for it.

Optional Feature:
Macro AER_DROP_COUNT_EN.
- Defined: adds output drop_count, 16 bits, reset 0. Increments per dropped spike, saturates at 16'hFFFF, cleared only by reset.
- Undefined: port and counter absent; overflow_flag alone reports loss.

Decomposition:
- Shared package/header: COORD_W, FIFO_DEPTH, GUARD_CYCLES defaults; state encodings S_IDLE/S_SEND/S_GUARD; AER word packing order {M,N}.
- One natural sub-module: aer_event_fifo. Synchronous single-clock FIFO with push/pop/full/empty/count. The encoder FSM, guard counter, done logic and the optional drop counter live in the top.

Test Plan:
- Single spike, M=3 N=7, busy=0 at cycle t -> AER_out=10'h067, flag high only in cycle t+2, AER_out held afterwards; no timestep_done without timestep_end.
- Spikes (1,2),(4,5),(9,31) queued while busy=1 -> no strobe while busy; after busy drops, words 10'h022, 10'h085, 10'h13F in order, strobes ≥5 cycles apart; busy re-raised after the first strobe holds the second until it falls.
- 17 back-to-back spikes with busy=1, depth 16 -> fifo_full after 16th, 17th dropped, overflow_flag=1; with AER_DROP_COUNT_EN drop_count=1; after release exactly 16 events emitted.
- Two spikes queued, then timestep_end pulsed twice -> exactly one timestep_done, after the second event's guard and with busy=0; a spike coincident with timestep_end is emitted before done.
- rst asserted during S_GUARD with 3 entries queued -> all outputs 0 immediately, FIFO empty; a later spike (0,0) emits AER_out=0 with flag at t+2.
- 40 paced spikes through the depth-16 FIFO, busy randomly toggled -> all 40 emitted in order, no overflow, pointers wrap correctly.

Source files
------------

// File: rtl/conv_layer_aer_encoder_pkg.sv
// Shared parameters, state encodings and AER word packing for the AER transmit encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package conv_layer_aer_encoder_pkg;

    localparam int COORD_W      = 5;
    localparam int AER_W        = 2 * COORD_W;
    localparam int FIFO_DEPTH   = 16;   // must be a power of two
    localparam int GUARD_CYCLES = 3;    // receiver flag-to-operating_flag latency is 2
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int GUARD_W      = $clog2(GUARD_CYCLES + 1);
    localparam int DROP_W       = 16;

    // One-hot encoder states
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SEND  = 3'b010,
        S_GUARD = 3'b100
    } enc_state_t;

    typedef logic [AER_W-1:0] aer_word_t;

    // AER word is {M, N}: row in the upper half, column in the lower half
    function automatic aer_word_t pack_aer(input logic [COORD_W-1:0] m,
                                           input logic [COORD_W-1:0] n);
        return {m, n};
    endfunction

endpackage

// File: rtl/conv_layer_aer_encoder_if.sv
// Bus between a conv layer's spike sweep, the AER encoder and the next layer's receiver.
// Latency: n/a (wires only).
// Backpressure: downstream_busy from the receiver; spikes beyond FIFO capacity are dropped.
// slave  : encoder side (spikes/timestep_end/busy in; AER word, strobe, status out)
// master : environment side (opposite directions)
// drop_count exists only when AER_DROP_COUNT_EN is defined.
interface conv_layer_aer_encoder_if;
    import conv_layer_aer_encoder_pkg::*;

    logic                spike_valid;
    logic [COORD_W-1:0]  spike_M;
    logic [COORD_W-1:0]  spike_N;
    logic                timestep_end;
    logic                downstream_busy;
    logic [AER_W-1:0]    AER_out;
    logic                AER_output_flag;
    logic                fifo_full;
    logic                overflow_flag;
    logic                timestep_done;
`ifdef AER_DROP_COUNT_EN
    logic [DROP_W-1:0]   drop_count;
`endif

    modport slave (
        input  spike_valid, spike_M, spike_N, timestep_end, downstream_busy,
`ifdef AER_DROP_COUNT_EN
        output drop_count,
`endif
        output AER_out, AER_output_flag, fifo_full, overflow_flag, timestep_done
    );

    modport master (
        output spike_valid, spike_M, spike_N, timestep_end, downstream_busy,
`ifdef AER_DROP_COUNT_EN
        input  drop_count,
`endif
        input  AER_out, AER_output_flag, fifo_full, overflow_flag, timestep_done
    );

endinterface

// File: rtl/conv_layer_aer_encoder_aer_event_fifo.sv
// Single-clock event FIFO: push/pop with registered full, count-derived empty.
// Latency: pushed word visible at head the cycle after the push edge.
// Backpressure: push ignored while full; pop ignored while empty.
// Ports: clk/rst, push+push_dat, pop -> pop_dat (head, combinational), full, empty, count.
module aer_event_fifo #(
    parameter  int W     = 10,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + (PW+1)'(1);
            2'b01:   count_nxt = count - (PW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (PW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/conv_layer_aer_encoder.sv
// AER transmit encoder: buffers layer spikes and emits paced {M,N} words with a one-cycle strobe.
// Latency: spike into empty FIFO with receiver idle -> strobe two cycles later; strobes >= GUARD_CYCLES+2 apart.
// Backpressure: holds events while downstream_busy; drops spikes when the FIFO is full (sticky overflow_flag).
// Ports: work_clk, rst (async, active-high), bus (conv_layer_aer_encoder_if.slave).
// Optional: define AER_DROP_COUNT_EN to add a saturating 16-bit drop_count on the bus.
module conv_layer_aer_encoder
    import conv_layer_aer_encoder_pkg::*;
(
    input logic                      work_clk,
    input logic                      rst,
    conv_layer_aer_encoder_if.slave  bus
);

    enc_state_t          state;
    logic [GUARD_W-1:0]  guard_cnt;
    aer_word_t           aer_out_q;
    logic                flag_q;
    logic                overflow_q;
    logic                done_pending;
    logic                done_q;

    aer_word_t           fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_push;
    logic                fifo_pop;
    logic                drop;
    logic                done_cond;

    // A spike arriving while full is lost even if a pop frees a slot in the same cycle
    assign drop      = bus.spike_valid && fifo_full;
    assign fifo_push = bus.spike_valid && !fifo_full;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty && !bus.downstream_busy;

    // Holding off on a same-cycle spike guarantees it drains before done is reported
    assign done_cond = done_pending && (fifo_count == '0) && (state == S_IDLE)
                    && !bus.downstream_busy && !bus.spike_valid;

    aer_event_fifo #(
        .W     (AER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (work_clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (pack_aer(bus.spike_M, bus.spike_N)),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Guard phase lasts GUARD_CYCLES cycles; downstream_busy is only re-sampled in S_IDLE
    always_ff @(posedge work_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
            aer_out_q <= '0;
            flag_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    flag_q <= 1'b0;
                    if (fifo_pop) begin
                        aer_out_q <= fifo_head;
                        flag_q    <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    flag_q    <= 1'b0;
                    guard_cnt <= GUARD_W'(GUARD_CYCLES);
                    state     <= S_GUARD;
                end
                S_GUARD: begin
                    flag_q    <= 1'b0;
                    guard_cnt <= guard_cnt - GUARD_W'(1);
                    if (guard_cnt <= GUARD_W'(1)) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    flag_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge work_clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            done_pending <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            done_q       <= done_cond;
            done_pending <= bus.timestep_end || (done_pending && !done_cond);
        end
    end

`ifdef AER_DROP_COUNT_EN
    logic [DROP_W-1:0] drop_cnt_q;

    always_ff @(posedge work_clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

    assign bus.AER_out         = aer_out_q;
    assign bus.AER_output_flag = flag_q;
    assign bus.fifo_full       = fifo_full;
    assign bus.overflow_flag   = overflow_q;
    assign bus.timestep_done   = done_q;

endmodule
